// File: rtl/display_scan_controller.sv
// Round-robin scan of NUM_DIGITS BCD digits onto one decoder path, with a blank gap between slots, double-buffered loads and optional leading-zero blanking.
// Outputs decode registered state only (no input->output path); load_ready drops while a frame-aligned update is pending.
module display_scan_controller #(
   parameter int NUM_DIGITS   = 4,
   parameter int CLK_DIV      = 50000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_load_valid,
   output logic                    o_load_ready,
   input  logic [4*NUM_DIGITS-1:0] i_load_digits,
   input  logic                    i_lz_blank_en,
   output logic [3:0]              o_bcd_out,
   output logic                    o_blank,
   output logic [NUM_DIGITS-1:0]   o_dig_sel,
   output logic                    o_frame_done
);
   localparam int IW   = $clog2(NUM_DIGITS);
   localparam int CMAX = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
   localparam int CW   = $clog2(CMAX);
   localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
   localparam logic [CW-1:0] SHOW_LAST  = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

   typedef enum logic {S_SHOW, S_BLANK} state_t;

   state_t                  r_state;
   logic [IW-1:0]           r_idx;
   logic [CW-1:0]           r_div_cnt;
   logic [4*NUM_DIGITS-1:0] r_active;
   logic [4*NUM_DIGITS-1:0] r_pending;
   logic                    r_pend_full;
   logic                    r_lz_en;

   logic                    w_show_end;
   logic                    w_blank_end;
   logic                    w_boundary;
   logic                    w_accept;
   logic                    w_upper_zero;
   logic [3:0]              w_bcd;

   assign w_show_end  = (r_state == S_SHOW)  && (r_div_cnt == SHOW_LAST);
   assign w_blank_end = (r_state == S_BLANK) && (r_div_cnt == BLANK_LAST);
   assign w_boundary  = w_blank_end && (r_idx == IDX_LAST);
   assign w_accept    = i_load_valid && !r_pend_full;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= S_SHOW;
         r_idx       <= '0;
         r_div_cnt   <= '0;
         r_active    <= '0;
         r_pending   <= '0;
         r_pend_full <= 1'b0;
         r_lz_en     <= 1'b0;
      end else begin
         r_lz_en <= i_lz_blank_en;
         case (r_state)
            S_SHOW: begin
               if (w_show_end) begin
                  r_state   <= S_BLANK;
                  r_div_cnt <= '0;
               end else begin
                  r_div_cnt <= r_div_cnt + 1'b1;
               end
            end
            S_BLANK: begin
               if (w_blank_end) begin
                  r_state   <= S_SHOW;
                  r_div_cnt <= '0;
                  r_idx     <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
               end else begin
                  r_div_cnt <= r_div_cnt + 1'b1;
               end
            end
         endcase
         // Swap only at the frame boundary so a frame is never torn; a full
         // pending buffer blocks acceptance, so copy and accept never collide.
         if (w_boundary && r_pend_full) begin
            r_active    <= r_pending;
            r_pend_full <= 1'b0;
         end else if (w_accept) begin
            r_pending   <= i_load_digits;
            r_pend_full <= 1'b1;
         end
      end
   end

   always_comb begin
      w_upper_zero = 1'b1;
      w_bcd        = 4'd0;
      for (int j = 0; j < NUM_DIGITS; j++) begin
         if (IW'(j) == r_idx)
            w_bcd = r_active[4*j +: 4];
         if ((IW'(j) >= r_idx) && (r_active[4*j +: 4] != 4'd0))
            w_upper_zero = 1'b0;
      end
   end

   assign o_bcd_out    = w_bcd;
   assign o_dig_sel    = (r_state == S_SHOW) ? (NUM_DIGITS'(1) << r_idx) : '0;
   assign o_blank      = (r_state == S_BLANK) | (r_lz_en && (r_idx != '0) && w_upper_zero);
   assign o_frame_done = w_boundary;
   assign o_load_ready = !r_pend_full;

endmodule

// File: tb/tb_display_scan_controller.sv
// Bench for display_scan_controller: directed scenarios then randomized loads, checked every cycle against a frame-arithmetic model.
module tb_display_scan_controller;
   localparam int N     = 4;
   localparam int CD    = 4;
   localparam int BC    = 2;
   localparam int SLOT  = CD + BC;
   localparam int FRAME = N * SLOT;

   logic        clk = 1'b0;
   logic        rst;
   logic        vld;
   logic        ready;
   logic [15:0] dig;
   logic        lz;
   logic [3:0]  bcd;
   logic        blank;
   logic [3:0]  sel;
   logic        fd;

   int checks   = 0;
   int failures = 0;

   // Reference model: time since reset, displayed value, pending buffer.
   int          m_t;
   logic [15:0] m_active;
   logic [15:0] m_pend;
   bit          m_full;
   bit          m_lz;
   bit          cur_lz;

   display_scan_controller #(.NUM_DIGITS(N), .CLK_DIV(CD), .BLANK_CYCLES(BC)) dut (
      .i_clk(clk), .i_rst(rst), .i_load_valid(vld), .o_load_ready(ready),
      .i_load_digits(dig), .i_lz_blank_en(lz), .o_bcd_out(bcd), .o_blank(blank),
      .o_dig_sel(sel), .o_frame_done(fd)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h t=%0d", tag, obs, exp, m_t);
      end
   endtask

   task automatic check_outputs();
      int          idx;
      bit          show;
      bit          lzb;
      logic [15:0] upper;
      idx   = (m_t % FRAME) / SLOT;
      show  = (m_t % SLOT) < CD;
      upper = m_active >> (4 * idx);
      lzb   = m_lz && (idx > 0) && (upper == 16'h0);
      check("dig_sel",    16'(sel),   show ? 16'(1 << idx) : 16'h0);
      check("bcd_out",    16'(bcd),   16'(upper[3:0]));
      check("blank",      16'(blank), 16'(!show || lzb));
      check("frame_done", 16'(fd),    16'((m_t % FRAME) == FRAME - 1));
      check("load_ready", 16'(ready), 16'(!m_full));
   endtask

   task automatic step(input bit r, input bit v, input logic [15:0] d, output bit acc);
      rst = r;
      vld = v;
      dig = d;
      lz  = cur_lz;
      acc = !r && v && !m_full;
      if (r) begin
         m_t = 0; m_active = 16'h0; m_full = 0; m_lz = 0;
      end else begin
         if (((m_t % FRAME) == FRAME - 1) && m_full) begin
            m_active = m_pend;
            m_full   = 0;
         end else if (acc) begin
            m_pend = d;
            m_full = 1;
         end
         m_lz = cur_lz;
         m_t++;
      end
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic idle(input int n);
      bit acc;
      repeat (n) step(1'b0, 1'b0, 16'h0, acc);
   endtask

   task automatic do_reset();
      bit acc;
      step(1'b1, 1'b0, 16'h0, acc);
   endtask

   task automatic offer(input logic [15:0] d);
      bit acc;
      int n;
      acc = 0;
      n   = 0;
      while (!acc && n < 100) begin
         step(1'b0, 1'b1, d, acc);
         n++;
      end
      checks++;
      assert (acc) else begin
         failures++;
         $error("FAIL offer_timeout observed=not_accepted expected=accepted data=%h", d);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (m_full && n < 200) begin
         idle(1);
         n++;
      end
   endtask

   task automatic align(input int pos);
      int n;
      n = 0;
      while ((m_t % FRAME) != pos && n < FRAME) begin
         idle(1);
         n++;
      end
   endtask

   initial begin
      bit          have;
      bit          acc;
      logic [15:0] pdat;
      int          k;
      rst = 1'b1; vld = 1'b0; dig = 16'h0; lz = 1'b0; cur_lz = 0;
      m_t = 0; m_active = 16'h0; m_pend = 16'h0; m_full = 0; m_lz = 0;
      #2;
      do_reset();

      // Scan timing, then a load accepted at cycle 3.
      idle(3);
      offer(16'h1234);
      idle(60);

      // Back-to-back loads: the second stalls until after the first boundary.
      offer(16'h1111);
      offer(16'h2222);
      idle(80);

      // Leading-zero blanking, including all-zero and non-BCD codes.
      cur_lz = 1;
      offer(16'h0070);
      drain();
      idle(30);
      offer(16'h0000);
      drain();
      idle(30);
      offer(16'h0A0F);
      drain();
      idle(10);
      cur_lz = 0;
      idle(20);

      // Load offered exactly in the boundary cycle.
      drain();
      align(FRAME - 1);
      offer(16'h5678);
      idle(60);

      // Reset mid-frame with pending full: old pending never shown.
      do_reset();
      idle(2);
      offer(16'h9ABC);
      align(10);
      do_reset();
      idle(60);

      // Randomized producer with lz toggling and occasional reset.
      have = 0;
      pdat = 16'h0;
      for (int c = 0; c < 700; c++) begin
         if (!have && $urandom_range(3) == 0) begin
            k    = $urandom_range(4);
            pdat = 16'($urandom & (32'h0000FFFF >> (4 * k)));
            have = 1;
         end
         if ($urandom_range(15) == 0) cur_lz = !cur_lz;
         if ($urandom_range(249) == 0) begin
            step(1'b1, 1'b0, 16'h0, acc);
            have = 0;
         end else begin
            step(1'b0, have, pdat, acc);
            if (acc) have = 0;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
